// File: rtl/clk_period_meter_if.sv
// Measurement bus of clk_period_meter: signal under test, control inputs and results.
interface clk_period_meter_if #(
  parameter int unsigned CNT_WIDTH = 28
);
  logic                 sig_in;
  logic                 start;
  logic                 continuous;
  logic                 busy;
  logic [CNT_WIDTH-1:0] period_out;
  logic [CNT_WIDTH-1:0] high_out;
  logic                 valid;
  logic                 timeout;

  modport master (
    output sig_in, start, continuous,
    input  busy, period_out, high_out, valid, timeout
  );

  modport slave (
    input  sig_in, start, continuous,
    output busy, period_out, high_out, valid, timeout
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous input in clock_in cycles,
// single-shot or back-to-back, aborting after TIMEOUT cycles without a closing edge.
module clk_period_meter #(
  parameter int unsigned CNT_WIDTH = 28,
  parameter int unsigned TIMEOUT   = 100000000
) (
  input  logic                clock_in,
  input  logic                reset,
  clk_period_meter_if.slave   mon
);

  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 high_seen_q, high_seen_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q, busy_d;
  logic                 s1_q, s2_q, s3_q;
  logic                 rise, fall;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // s1/s2 resynchronise sig_in; s3 is the previous synchronised sample.
  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    high_d      = high_q;
    high_seen_d = high_seen_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mon.start) begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
      end

      ST_ARM: begin
        if (rise) begin
          state_d     = ST_MEASURE;
          cnt_d       = '0;
          high_seen_d = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_MEASURE: begin
        // A closing rise also opens the next period when running continuously.
        if (rise) begin
          period_d    = cnt_inc;
          valid_d     = 1'b1;
          cnt_d       = '0;
          high_seen_d = 1'b0;
          state_d     = mon.continuous ? ST_MEASURE : ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (fall && !high_seen_q) begin
            high_d      = cnt_inc;
            high_seen_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      high_q      <= '0;
      high_seen_q <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      high_seen_q <= high_seen_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      s1_q        <= mon.sig_in;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
    end
  end

  assign mon.busy       = busy_q;
  assign mon.period_out = period_q;
  assign mon.high_out   = high_q;
  assign mon.valid      = valid_q;
  assign mon.timeout    = timeout_q;

endmodule
